// File: rtl/nfmac10g_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nfmac10g_pkg
//  Description : Shared definitions for the 10G MAC TX path: AXIS widths,
//                arbiter state encodings and the abort-beat byte enable.
//                Also provides the round-robin pointer advance helper.
//  Revision    : 1.0  initial release
// ============================================================================
package nfmac10g_pkg;

    localparam int TDATA_W = 64;
    localparam int TKEEP_W = 8;

    // Byte enable of the single-byte abort beat sent to the MAC.
    localparam logic [TKEEP_W-1:0] TKEEP_ONE = 8'h01;

    // One-hot arbiter states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_PKT   = 3'b010,
        ST_FLUSH = 3'b100
    } arb_state_t;

    // Pointer to the source after idx, wrapping n-1 -> 0.
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_tx_rr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_tx_rr_arb_if
//  Description : AXI4-Stream bundle of LANES parallel 64-bit streams.
//                Lane k occupies tdata[64k+63:64k], tkeep[8k+7:8k] and bit k
//                of tvalid/tlast/tuser/tready.
//                modport master : drives tdata/tkeep/tvalid/tlast/tuser
//                modport slave  : drives tready
//  Revision    : 1.0  initial release
// ============================================================================
interface axis_tx_rr_arb_if #(
    parameter int LANES = 1
);
    import nfmac10g_pkg::*;

    logic [LANES*TDATA_W-1:0] tdata;
    logic [LANES*TKEEP_W-1:0] tkeep;
    logic [LANES-1:0]         tvalid;
    logic [LANES-1:0]         tlast;
    logic [LANES-1:0]         tuser;
    logic [LANES-1:0]         tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/axis_tx_rr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first
//                requesting index at or after ptr, modulo N_SRC.
//  Ports       : req     in  N_SRC  request vector
//                ptr     in  3      search start (must be < N_SRC)
//                gnt_idx out 3      chosen index (0 when nothing requests)
//                any     out 1      at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N_SRC = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       gnt_idx,
    output logic             any
);

    int w_v;

    assign any = |req;

    // Walk offsets from farthest to nearest so the nearest request
    // at or after ptr is the last (and therefore winning) assignment.
    always_comb begin
        gnt_idx = 3'd0;
        w_v     = 0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            w_v = int'(ptr) + i;
            if (w_v >= N_SRC) begin
                w_v = w_v - N_SRC;
            end
            if (req[w_v]) begin
                gnt_idx = 3'(w_v);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_tx_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : axis_tx_rr_arb
//  Description : Packet-granular round-robin arbiter sharing the 64-bit MAC
//                TX AXIS among N_SRC packet sources. A whole frame is granted
//                and forwarded before re-arbitration; frames never interleave.
//  Ports       : clk        in   clock, rising edge
//                reset      in   synchronous, active-high
//                s_axis     slave  N_SRC-lane source bundle
//                m_axis     master 1-lane bundle towards the MAC
//                grant_idx  out  index of the owning source (valid when busy)
//                busy       out  frame in progress
//  Config      : TX_ARB_WDOG_EN - when defined, a mid-frame starvation
//                watchdog (WDOG_CYCLES) aborts the frame at the MAC and
//                flushes the rest of it from the owning source.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_tx_rr_arb
    import nfmac10g_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int WDOG_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    axis_tx_rr_arb_if.slave  s_axis,
    axis_tx_rr_arb_if.master m_axis,
    output logic [2:0]       grant_idx,
    output logic             busy
);

    // ------------------------------------------------------------------
    // Lane unpacking. Arrays are padded to 8 entries so the 3-bit grant
    // index addresses them without width adaptation.
    // ------------------------------------------------------------------
    logic [TDATA_W-1:0] w_lane_data [8];
    logic [TKEEP_W-1:0] w_lane_keep [8];
    logic [7:0]         w_lane_valid;
    logic [7:0]         w_lane_last;
    logic [7:0]         w_lane_user;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        if (k < N_SRC) begin : g_used
            assign w_lane_data[k]  = s_axis.tdata[k*TDATA_W +: TDATA_W];
            assign w_lane_keep[k]  = s_axis.tkeep[k*TKEEP_W +: TKEEP_W];
            assign w_lane_valid[k] = s_axis.tvalid[k];
            assign w_lane_last[k]  = s_axis.tlast[k];
            assign w_lane_user[k]  = s_axis.tuser[k];
        end else begin : g_unused
            assign w_lane_data[k]  = '0;
            assign w_lane_keep[k]  = '0;
            assign w_lane_valid[k] = 1'b0;
            assign w_lane_last[k]  = 1'b0;
            assign w_lane_user[k]  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and granted-lane selection
    // ------------------------------------------------------------------
    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [2:0] r_rr_ptr;
    logic [2:0] w_rr_ptr_nxt;
    logic [2:0] r_grant;
    logic [2:0] w_grant_nxt;
    logic       w_rdy_own;

    logic [TDATA_W-1:0] w_sel_data;
    logic [TKEEP_W-1:0] w_sel_keep;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_sel_user;

    assign w_sel_data  = w_lane_data[r_grant];
    assign w_sel_keep  = w_lane_keep[r_grant];
    assign w_sel_valid = w_lane_valid[r_grant];
    assign w_sel_last  = w_lane_last[r_grant];
    assign w_sel_user  = w_lane_user[r_grant];

    logic [2:0] w_pick_idx;
    logic       w_pick_any;

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req     (s_axis.tvalid),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    // ------------------------------------------------------------------
    // Starvation watchdog
    // ------------------------------------------------------------------
`ifdef TX_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              w_wdog_fire;

    assign w_wdog_fire = (r_wdog == WDOG_W'(WDOG_CYCLES));

    // Once the limit is reached the count is frozen so the abort beat
    // stays asserted until the MAC takes it, even if the owner resumes.
    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_PKT)) begin
            r_wdog <= '0;
        end else if (w_wdog_fire) begin
            r_wdog <= r_wdog;
        end else if (w_sel_valid) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    // The starvation limit has no effect when the watchdog is absent.
    if (WDOG_CYCLES < 1) begin : g_wdog_unused
    end
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= 3'd0;
            r_grant  <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_grant  <= w_grant_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_rdy_own     = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tkeep  = '0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Grant is registered, giving one bubble cycle per frame.
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ST_PKT;
                end
            end

            ST_PKT: begin
`ifdef TX_ARB_WDOG_EN
                if (w_wdog_fire) begin
                    m_axis.tvalid = 1'b1;
                    m_axis.tlast  = 1'b1;
                    m_axis.tuser  = 1'b1;
                    m_axis.tkeep  = TKEEP_ONE;
                    if (m_axis.tready) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end else begin
`endif
                    m_axis.tdata  = w_sel_data;
                    m_axis.tkeep  = w_sel_keep;
                    m_axis.tvalid = w_sel_valid;
                    m_axis.tlast  = w_sel_last;
                    m_axis.tuser  = w_sel_user & w_sel_last;
                    w_rdy_own     = m_axis.tready;
                    if (w_sel_valid && m_axis.tready && w_sel_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = rr_next(r_grant, N_SRC);
                    end
`ifdef TX_ARB_WDOG_EN
                end
`endif
            end

`ifdef TX_ARB_WDOG_EN
            ST_FLUSH: begin
                // Remainder of the aborted frame is consumed and dropped.
                w_rdy_own = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = rr_next(r_grant, N_SRC);
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Only the owning source ever sees ready.
    always_comb begin
        s_axis.tready = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (r_grant == 3'(k)) begin
                s_axis.tready[k] = w_rdy_own;
            end
        end
    end

    assign grant_idx = r_grant;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_tx_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_tx_rr_arb
//  Description : Directed self-checking bench for axis_tx_rr_arb, N_SRC=4,
//                WDOG_CYCLES=16. Each source is a small frame generator whose
//                beat payload encodes {source, frame, beat}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_tx_rr_arb;
    import nfmac10g_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] grant_idx;
    logic       busy;

    always #5 clk = ~clk;

    axis_tx_rr_arb_if #(.LANES(N)) s_if ();
    axis_tx_rr_arb_if #(.LANES(1)) m_if ();

    axis_tx_rr_arb #(
        .N_SRC       (N),
        .WDOG_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    // ---------------- scoreboard / counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [2:0]  grant;
        int          cyc;
    } beat_t;

    beat_t mon_q[$];

    // ---------------- source models ----------------
    int          frames_left [N];
    int          len         [N];
    int          beat        [N];
    int          frame       [N];
    int          hold        [N];
    int          stall_at    [N];
    int          stall_len   [N];
    logic        user_flag   [N];
    logic [7:0]  last_keep   [N];
    logic [N-1:0] acc_q;

    logic rst_req;
    logic rdy_req;
    logic rdy_toggle;
    int   cyc;
    int   mirror_err;

    function automatic logic [63:0] beat_data(input int k, input int f, input int b);
        return {16'hC0DE, 8'(k), 8'(f), 32'(b)};
    endfunction

    // One clock: apply last cycle's handshakes, drive, then sample at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (hold[k] > 0) begin
                hold[k]--;
            end else if (acc_q[k]) begin
                if (beat[k] == len[k] - 1) begin
                    beat[k] = 0;
                    frame[k]++;
                    frames_left[k]--;
                end else begin
                    beat[k]++;
                    if (beat[k] == stall_at[k]) hold[k] = stall_len[k];
                end
            end
        end
        reset        = rst_req;
        m_if.tready[0] = rdy_toggle ? ~m_if.tready[0] : rdy_req;
        for (int k = 0; k < N; k++) begin
            s_if.tvalid[k]          = (frames_left[k] > 0) && (hold[k] == 0);
            s_if.tdata[k*64 +: 64]  = beat_data(k, frame[k], beat[k]);
            s_if.tlast[k]           = (beat[k] == len[k] - 1);
            s_if.tkeep[k*8 +: 8]    = (beat[k] == len[k] - 1) ? last_keep[k] : 8'hFF;
            s_if.tuser[k]           = user_flag[k];
        end
        @(negedge clk);
        acc_q = s_if.tvalid & s_if.tready;
        if (m_if.tvalid[0] && m_if.tready[0]) begin
            mon_q.push_back('{data: m_if.tdata, keep: m_if.tkeep, last: m_if.tlast[0],
                              user: m_if.tuser[0], grant: grant_idx, cyc: cyc});
        end
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < N; k++) if (frames_left[k] > 0) return 1'b0;
        return !busy;
    endfunction

    // Runs until every source finished and the arbiter is idle, bounded.
    // mirror_src >= 0 also tallies ready-mirroring errors for that source.
    task automatic run_until_idle(input string tag, input int budget, input int mirror_src);
        int n;
        bit done;
        logic [N-1:0] exp_rdy;
        n    = 0;
        done = 1'b0;
        while (n < budget && !done) begin
            tick();
            n++;
            if (mirror_src >= 0 && busy) begin
                exp_rdy = m_if.tready[0] ? (N'(1) << mirror_src) : '0;
                if (s_if.tready !== exp_rdy) mirror_err++;
            end
            done = all_idle();
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic expect_beat(input string tag, input int idx, input logic [63:0] data,
                               input logic [7:0] keep, input logic last, input logic user,
                               input logic [2:0] grant);
        if (idx >= mon_q.size()) begin
            check_eq($sformatf("%s%0d_present", tag, idx), 64'(mon_q.size()), 64'(idx + 1));
        end else begin
            check_eq($sformatf("%s%0d_data", tag, idx), mon_q[idx].data, data);
            check_eq($sformatf("%s%0d_meta", tag, idx),
                     64'({mon_q[idx].keep, mon_q[idx].last, mon_q[idx].user, mon_q[idx].grant}),
                     64'({keep, last, user, grant}));
        end
    endtask

    task automatic src_cfg(input int k, input int frames, input int l);
        frames_left[k] = frames;
        len[k]         = l;
        beat[k]        = 0;
        hold[k]        = 0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset          = 1'b1;
        s_if.tdata     = '0;
        s_if.tkeep     = '0;
        s_if.tvalid    = '0;
        s_if.tlast     = '0;
        s_if.tuser     = '0;
        m_if.tready    = '0;
        acc_q          = '0;
        rst_req        = 1'b1;
        rdy_req        = 1'b0;
        rdy_toggle     = 1'b0;
        cyc            = 0;
        mirror_err     = 0;
        for (int k = 0; k < N; k++) begin
            frames_left[k] = 0;
            len[k]         = 1;
            beat[k]        = 0;
            frame[k]       = 0;
            hold[k]        = 0;
            stall_at[k]    = -1;
            stall_len[k]   = 0;
            user_flag[k]   = 1'b0;
            last_keep[k]   = 8'hFF;
        end

        // 1: reset values
        repeat (3) tick();
        check_eq("rst_busy",   64'(busy),         64'd0);
        check_eq("rst_mvalid", 64'(m_if.tvalid),  64'd0);
        check_eq("rst_sready", 64'(s_if.tready),  64'd0);
        check_eq("rst_grant",  64'(grant_idx),    64'd0);
        rst_req = 1'b0;
        rdy_req = 1'b1;
        tick();

        // 2: fairness, four sources x two 8-beat frames
        mon_q.delete();
        for (int k = 0; k < N; k++) src_cfg(k, 2, 8);
        run_until_idle("fair", 200, -1);
        check_eq("fair_count", 64'(mon_q.size()), 64'd64);
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 8; b++) begin
                expect_beat("fair", j*8 + b, beat_data(j % 4, j / 4, b), 8'hFF,
                            (b == 7), 1'b0, 3'(j % 4));
            end
            if (j > 0 && mon_q.size() == 64) begin
                check_eq($sformatf("fair_period%0d", j),
                         64'(mon_q[j*8].cyc - mon_q[(j-1)*8].cyc), 64'd9);
            end
        end

        // 3: backpressure on source 1, ready toggling
        mon_q.delete();
        mirror_err    = 0;
        rdy_toggle    = 1'b1;
        last_keep[1]  = 8'h0F;
        src_cfg(1, 1, 3);
        run_until_idle("bp", 40, 1);
        rdy_toggle    = 1'b0;
        last_keep[1]  = 8'hFF;
        check_eq("bp_mirror", 64'(mirror_err), 64'd0);
        check_eq("bp_count",  64'(mon_q.size()), 64'd3);
        expect_beat("bp", 0, beat_data(1, 2, 0), 8'hFF, 1'b0, 1'b0, 3'd1);
        expect_beat("bp", 1, beat_data(1, 2, 1), 8'hFF, 1'b0, 1'b0, 3'd1);
        expect_beat("bp", 2, beat_data(1, 2, 2), 8'h0F, 1'b1, 1'b0, 3'd1);

        // 4: no interleave; source 2 requests while source 0 is mid-frame
        mon_q.delete();
        user_flag[0] = 1'b1;
        src_cfg(0, 1, 4);
        repeat (3) tick();
        src_cfg(2, 1, 2);
        run_until_idle("nil", 40, -1);
        user_flag[0] = 1'b0;
        check_eq("nil_count", 64'(mon_q.size()), 64'd6);
        expect_beat("nil", 0, beat_data(0, 2, 0), 8'hFF, 1'b0, 1'b0, 3'd0);
        expect_beat("nil", 1, beat_data(0, 2, 1), 8'hFF, 1'b0, 1'b0, 3'd0);
        expect_beat("nil", 2, beat_data(0, 2, 2), 8'hFF, 1'b0, 1'b0, 3'd0);
        expect_beat("nil", 3, beat_data(0, 2, 3), 8'hFF, 1'b1, 1'b1, 3'd0);
        expect_beat("nil", 4, beat_data(2, 2, 0), 8'hFF, 1'b0, 1'b0, 3'd2);
        expect_beat("nil", 5, beat_data(2, 2, 1), 8'hFF, 1'b1, 1'b0, 3'd2);
        if (mon_q.size() == 6) begin
            check_eq("nil_gap", 64'(mon_q[4].cyc - mon_q[3].cyc), 64'd2);
        end

        // 5: reset during beat 4 of an 8-beat frame from source 0
        mon_q.delete();
        src_cfg(0, 1, 8);
        for (int n = 0; n < 20 && mon_q.size() < 3; n++) tick();
        check_eq("mr_pre_beats", 64'(mon_q.size()), 64'd3);
        rst_req = 1'b1;
        tick();
        tick();
        check_eq("mr_busy",   64'(busy),        64'd0);
        check_eq("mr_mvalid", 64'(m_if.tvalid), 64'd0);
        check_eq("mr_sready", 64'(s_if.tready), 64'd0);
        check_eq("mr_grant",  64'(grant_idx),   64'd0);
        rst_req        = 1'b0;
        frames_left[0] = 0;
        beat[0]        = 0;
        // Sources 1 and 3 together: a cleared pointer grants 1 before 3.
        mon_q.delete();
        src_cfg(1, 1, 2);
        src_cfg(3, 1, 2);
        run_until_idle("mr", 40, -1);
        expect_beat("mr", 0, beat_data(1, 3, 0), 8'hFF, 1'b0, 1'b0, 3'd1);
        expect_beat("mr", 1, beat_data(1, 3, 1), 8'hFF, 1'b1, 1'b0, 3'd1);
        expect_beat("mr", 2, beat_data(3, 2, 0), 8'hFF, 1'b0, 1'b0, 3'd3);
        expect_beat("mr", 3, beat_data(3, 2, 1), 8'hFF, 1'b1, 1'b0, 3'd3);

        // 6: source 0 stalls for 16 cycles after 2 beats; source 1 waits
        mon_q.delete();
        stall_at[0]  = 2;
        stall_len[0] = 16;
        src_cfg(0, 1, 6);
        src_cfg(1, 1, 2);
        repeat (12) tick();
        check_eq("st_busy",   64'(busy),        64'd1);
        check_eq("st_grant",  64'(grant_idx),   64'd0);
        check_eq("st_mvalid", 64'(m_if.tvalid), 64'd0);
        run_until_idle("st", 80, -1);
        stall_at[0] = -1;
        check_eq("st_src0_drained", 64'(frames_left[0]), 64'd0);
        expect_beat("st", 0, beat_data(0, 3, 0), 8'hFF, 1'b0, 1'b0, 3'd0);
        expect_beat("st", 1, beat_data(0, 3, 1), 8'hFF, 1'b0, 1'b0, 3'd0);
`ifdef TX_ARB_WDOG_EN
        check_eq("st_count", 64'(mon_q.size()), 64'd5);
        expect_beat("st", 2, 64'd0, 8'h01, 1'b1, 1'b1, 3'd0);
        expect_beat("st", 3, beat_data(1, 4, 0), 8'hFF, 1'b0, 1'b0, 3'd1);
        expect_beat("st", 4, beat_data(1, 4, 1), 8'hFF, 1'b1, 1'b0, 3'd1);
`else
        check_eq("st_count", 64'(mon_q.size()), 64'd8);
        for (int b = 2; b < 6; b++) begin
            expect_beat("st", b, beat_data(0, 3, b), 8'hFF, (b == 5), 1'b0, 3'd0);
        end
        expect_beat("st", 6, beat_data(1, 4, 0), 8'hFF, 1'b0, 1'b0, 3'd1);
        expect_beat("st", 7, beat_data(1, 4, 1), 8'hFF, 1'b1, 1'b0, 3'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
